// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv - shared types and golden functions for the cell BIST controllers
package gf180mcu_fd_sc_mcu7t5v0__bist_pkg;

    localparam int VEC_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FIN
    } bist_state_t;

    // vec = {A1,A2,B,C}
    function automatic logic oai211_exp(input logic [VEC_W-1:0] vec);
        return ~((vec[3] | vec[2]) & vec[1] & vec[0]);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_settle_tmr.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__bist_settle_tmr.sv - loadable 4-bit settle down-counter with zero flag
module gf180mcu_fd_sc_mcu7t5v0__bist_settle_tmr (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_bist_ctrl.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_bist_ctrl.sv - 16-vector BIST sequencer for one oai211 cell
module gf180mcu_fd_sc_mcu7t5v0__oai211_bist_ctrl
    import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 5
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    output logic             A1,
    output logic             A2,
    output logic             B,
    output logic             C,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VLD,
    output logic [3:0]       FAIL_VEC
);

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] VEC_LAST  = '1;

    bist_state_t      r_state;
    bist_state_t      w_state_nxt;
    logic [VEC_W-1:0] r_vec;
    logic [VEC_W-1:0] r_stim;
    logic             r_busy;
    logic             r_done;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_fail_vld;
    logic [VEC_W-1:0] r_fail_vec;

    logic w_active;
    logic w_start_go;
    logic w_abort_go;
    logic w_mis;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_zero;

    assign w_active   = (r_state == APPLY) || (r_state == SETTLE) || (r_state == SAMPLE);
    assign w_start_go = START && !ABORT && ((r_state == IDLE) || (r_state == FIN));
    assign w_abort_go = ABORT && w_active;
    // 4-state compare so an X/Z from an open or contended cell output is a mismatch
    assign w_mis      = (ZN !== oai211_exp(r_vec));

    gf180mcu_fd_sc_mcu7t5v0__bist_settle_tmr u_settle_tmr (
        .i_clk      (CLK),
        .i_rst_n    (RN),
        .i_load     (w_tmr_load),
        .i_load_val (SETTLE_LD),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        case (r_state)
            IDLE, FIN: begin
                if (w_start_go) w_state_nxt = APPLY;
            end
            APPLY: begin
                w_state_nxt = SETTLE;
                w_tmr_load  = 1'b1;
            end
            SETTLE: begin
                if (w_tmr_zero) w_state_nxt = SAMPLE;
                else            w_tmr_dec   = 1'b1;
            end
            SAMPLE: begin
                w_state_nxt = (r_vec == VEC_LAST) ? FIN : APPLY;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort_go) w_state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_vec      <= '0;
            r_stim     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
        end else if (w_start_go) begin
            r_vec      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
        end else if (w_abort_go) begin
            // partial error results are kept for the test master to read
            r_busy <= 1'b0;
            r_stim <= '0;
        end else begin
            case (r_state)
                APPLY: r_stim <= r_vec;
                SAMPLE: begin
                    if (w_mis) begin
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
                        if (!r_fail_vld) begin
                            r_fail_vld <= 1'b1;
                            r_fail_vec <= r_vec;
                        end
                    end
                    if (r_vec == VEC_LAST) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_stim <= '0;
                    end else begin
                        r_vec <= r_vec + VEC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign {A1, A2, B, C} = r_stim;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_done & (r_err_cnt == '0);
    assign ERR_CNT  = r_err_cnt;
    assign FAIL_VLD = r_fail_vld;
    assign FAIL_VEC = r_fail_vec;

endmodule
